// File: rtl/alu_rs.sv
// alu_rs: reservation station in front of the integer ALU; holds micro-ops until operands resolve.
// Define ALU_RS_DUAL_CDB_EN to add a second snooped broadcast bus (cdb2_*) for the load buffer.
module alu_rs #(
  parameter int RS_SIZE = 8,
  parameter int TAG_W   = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush,
  input  logic             disp_valid,
  input  logic [4:0]       disp_op,
  input  logic [31:0]      disp_vj,
  input  logic [TAG_W-1:0] disp_qj,
  input  logic             disp_qj_busy,
  input  logic [31:0]      disp_vk,
  input  logic [TAG_W-1:0] disp_qk,
  input  logic             disp_qk_busy,
  input  logic [31:0]      disp_pc,
  input  logic [TAG_W-1:0] disp_dest,
  output logic             rs_full,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
`ifdef ALU_RS_DUAL_CDB_EN
  input  logic             cdb2_valid,
  input  logic [TAG_W-1:0] cdb2_tag,
  input  logic [31:0]      cdb2_value,
`endif
  output logic             alu_valid,
  output logic [4:0]       alu_op,
  output logic [31:0]      alu_op1,
  output logic [31:0]      alu_op2,
  output logic [31:0]      alu_addr,
  output logic [TAG_W-1:0] alu_dest
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  typedef struct packed {
    logic        busy;
    logic [31:0] val;
  } opnd_t;

  logic [RS_SIZE-1:0] busy_q, busy_d;
  logic [RS_SIZE-1:0] qj_busy_q, qj_busy_d;
  logic [RS_SIZE-1:0] qk_busy_q, qk_busy_d;
  logic [4:0]         op_q   [RS_SIZE];
  logic [4:0]         op_d   [RS_SIZE];
  logic [31:0]        vj_q   [RS_SIZE];
  logic [31:0]        vj_d   [RS_SIZE];
  logic [31:0]        vk_q   [RS_SIZE];
  logic [31:0]        vk_d   [RS_SIZE];
  logic [31:0]        pc_q   [RS_SIZE];
  logic [31:0]        pc_d   [RS_SIZE];
  logic [TAG_W-1:0]   qj_q   [RS_SIZE];
  logic [TAG_W-1:0]   qj_d   [RS_SIZE];
  logic [TAG_W-1:0]   qk_q   [RS_SIZE];
  logic [TAG_W-1:0]   qk_d   [RS_SIZE];
  logic [TAG_W-1:0]   dest_q [RS_SIZE];
  logic [TAG_W-1:0]   dest_d [RS_SIZE];

  logic               alu_valid_q, alu_valid_d;
  logic [4:0]         alu_op_q, alu_op_d;
  logic [31:0]        alu_op1_q, alu_op1_d;
  logic [31:0]        alu_op2_q, alu_op2_d;
  logic [31:0]        alu_addr_q, alu_addr_d;
  logic [TAG_W-1:0]   alu_dest_q, alu_dest_d;

  logic [RS_SIZE-1:0] ready;
  logic               issue_any;
  logic [IDX_W-1:0]   issue_idx;
  logic               alloc_any;
  logic [IDX_W-1:0]   alloc_idx;
  opnd_t              wake_j [RS_SIZE];
  opnd_t              wake_k [RS_SIZE];
  opnd_t              disp_j, disp_k;

  // Resolve a waiting operand against one broadcast bus; an already-resolved operand passes through,
  // so chaining the primary bus first gives it priority over the second.
  function automatic opnd_t snoop(input opnd_t cur, input logic [TAG_W-1:0] tag,
                                  input logic bus_v, input logic [TAG_W-1:0] bus_tag,
                                  input logic [31:0] bus_val);
    opnd_t r;
    r = cur;
    if (cur.busy && bus_v && (tag == bus_tag)) begin
      r.busy = 1'b0;
      r.val  = bus_val;
    end else begin
      r = cur;
    end
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] lowest(input logic [RS_SIZE-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (v[i]) begin
        r = IDX_W'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  assign rs_full   = &busy_q;
  assign ready     = busy_q & ~qj_busy_q & ~qk_busy_q;
  assign issue_any = |ready;
  assign issue_idx = lowest(ready);
  assign alloc_any = ~rs_full;
  assign alloc_idx = lowest(~busy_q);

  // Operand snooping for stored entries and for the operands being dispatched this cycle.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      wake_j[i] = snoop('{busy: qj_busy_q[i], val: vj_q[i]}, qj_q[i], cdb_valid, cdb_tag, cdb_value);
      wake_k[i] = snoop('{busy: qk_busy_q[i], val: vk_q[i]}, qk_q[i], cdb_valid, cdb_tag, cdb_value);
`ifdef ALU_RS_DUAL_CDB_EN
      wake_j[i] = snoop(wake_j[i], qj_q[i], cdb2_valid, cdb2_tag, cdb2_value);
      wake_k[i] = snoop(wake_k[i], qk_q[i], cdb2_valid, cdb2_tag, cdb2_value);
`endif
    end
    disp_j = snoop('{busy: disp_qj_busy, val: disp_vj}, disp_qj, cdb_valid, cdb_tag, cdb_value);
    disp_k = snoop('{busy: disp_qk_busy, val: disp_vk}, disp_qk, cdb_valid, cdb_tag, cdb_value);
`ifdef ALU_RS_DUAL_CDB_EN
    disp_j = snoop(disp_j, disp_qj, cdb2_valid, cdb2_tag, cdb2_value);
    disp_k = snoop(disp_k, disp_qk, cdb2_valid, cdb2_tag, cdb2_value);
`endif
  end

  // Next-state: flush beats everything, rdy_in low freezes entries, otherwise wake, issue and allocate.
  always_comb begin
    busy_d     = busy_q;
    qj_busy_d  = qj_busy_q;
    qk_busy_d  = qk_busy_q;
    op_d       = op_q;
    vj_d       = vj_q;
    vk_d       = vk_q;
    pc_d       = pc_q;
    qj_d       = qj_q;
    qk_d       = qk_q;
    dest_d     = dest_q;
    alu_valid_d = 1'b0;
    alu_op_d   = alu_op_q;
    alu_op1_d  = alu_op1_q;
    alu_op2_d  = alu_op2_q;
    alu_addr_d = alu_addr_q;
    alu_dest_d = alu_dest_q;
    if (flush) begin
      busy_d = '0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        vj_d[i]      = wake_j[i].val;
        qj_busy_d[i] = wake_j[i].busy;
        vk_d[i]      = wake_k[i].val;
        qk_busy_d[i] = wake_k[i].busy;
      end
      // The issued entry is ready, so its stored operands are final and unaffected by wakeup.
      if (issue_any) begin
        alu_valid_d       = 1'b1;
        alu_op_d          = op_q[issue_idx];
        alu_op1_d         = vj_q[issue_idx];
        alu_op2_d         = vk_q[issue_idx];
        alu_addr_d        = pc_q[issue_idx];
        alu_dest_d        = dest_q[issue_idx];
        busy_d[issue_idx] = 1'b0;
      end else begin
        alu_valid_d = 1'b0;
      end
      if (disp_valid && alloc_any) begin
        busy_d[alloc_idx]    = 1'b1;
        op_d[alloc_idx]      = disp_op;
        vj_d[alloc_idx]      = disp_j.val;
        qj_busy_d[alloc_idx] = disp_j.busy;
        qj_d[alloc_idx]      = disp_qj;
        vk_d[alloc_idx]      = disp_k.val;
        qk_busy_d[alloc_idx] = disp_k.busy;
        qk_d[alloc_idx]      = disp_qk;
        pc_d[alloc_idx]      = disp_pc;
        dest_d[alloc_idx]    = disp_dest;
      end else begin
        busy_d[alloc_idx] = busy_d[alloc_idx];
      end
    end else begin
      alu_valid_d = 1'b0;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q      <= '0;
      qj_busy_q   <= '0;
      qk_busy_q   <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        op_q[i]   <= 5'd0;
        vj_q[i]   <= 32'd0;
        vk_q[i]   <= 32'd0;
        pc_q[i]   <= 32'd0;
        qj_q[i]   <= '0;
        qk_q[i]   <= '0;
        dest_q[i] <= '0;
      end
      alu_valid_q <= 1'b0;
      alu_op_q    <= 5'd0;
      alu_op1_q   <= 32'd0;
      alu_op2_q   <= 32'd0;
      alu_addr_q  <= 32'd0;
      alu_dest_q  <= '0;
    end else begin
      busy_q      <= busy_d;
      qj_busy_q   <= qj_busy_d;
      qk_busy_q   <= qk_busy_d;
      op_q        <= op_d;
      vj_q        <= vj_d;
      vk_q        <= vk_d;
      pc_q        <= pc_d;
      qj_q        <= qj_d;
      qk_q        <= qk_d;
      dest_q      <= dest_d;
      alu_valid_q <= alu_valid_d;
      alu_op_q    <= alu_op_d;
      alu_op1_q   <= alu_op1_d;
      alu_op2_q   <= alu_op2_d;
      alu_addr_q  <= alu_addr_d;
      alu_dest_q  <= alu_dest_d;
    end
  end

  assign alu_valid = alu_valid_q;
  assign alu_op    = alu_op_q;
  assign alu_op1   = alu_op1_q;
  assign alu_op2   = alu_op2_q;
  assign alu_addr  = alu_addr_q;
  assign alu_dest  = alu_dest_q;

endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed plan plus random traffic, checked by an entry-level model and an issue scoreboard.
module tb_alu_rs;
  localparam int N  = 8;
  localparam int TW = 4;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic rdy_in = 1'b1;
  logic flush = 1'b0;
  logic disp_valid = 1'b0;
  logic [4:0] disp_op = 5'd0;
  logic [31:0] disp_vj = 32'd0, disp_vk = 32'd0, disp_pc = 32'd0;
  logic [TW-1:0] disp_qj = '0, disp_qk = '0, disp_dest = '0;
  logic disp_qj_busy = 1'b0, disp_qk_busy = 1'b0;
  logic rs_full;
  logic cdb_valid = 1'b0;
  logic [TW-1:0] cdb_tag = '0;
  logic [31:0] cdb_value = 32'd0;
`ifdef ALU_RS_DUAL_CDB_EN
  logic cdb2_valid = 1'b0;
  logic [TW-1:0] cdb2_tag = '0;
  logic [31:0] cdb2_value = 32'd0;
`endif
  logic alu_valid;
  logic [4:0] alu_op;
  logic [31:0] alu_op1, alu_op2, alu_addr;
  logic [TW-1:0] alu_dest;

  alu_rs #(.RS_SIZE(N), .TAG_W(TW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .disp_valid(disp_valid), .disp_op(disp_op), .disp_vj(disp_vj), .disp_qj(disp_qj),
    .disp_qj_busy(disp_qj_busy), .disp_vk(disp_vk), .disp_qk(disp_qk),
    .disp_qk_busy(disp_qk_busy), .disp_pc(disp_pc), .disp_dest(disp_dest),
    .rs_full(rs_full), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
`ifdef ALU_RS_DUAL_CDB_EN
    .cdb2_valid(cdb2_valid), .cdb2_tag(cdb2_tag), .cdb2_value(cdb2_value),
`endif
    .alu_valid(alu_valid), .alu_op(alu_op), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_addr(alu_addr), .alu_dest(alu_dest)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit busy;
    bit [4:0] op;
    bit [31:0] a, b, pc;
    bit a_wait, b_wait;
    bit [TW-1:0] ta, tb, dest;
  } slot_t;

  typedef struct {
    bit [4:0] op;
    bit [31:0] a, b, pc;
    bit [TW-1:0] dest;
  } iss_t;

  slot_t slots [N];
  iss_t  exp_q [$];
  bit    exp_valid = 1'b0;
  bit    exp_full = 1'b0;
  int    n_checks = 0;
  int    n_pass = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    foreach (slots[i]) slots[i].busy = 1'b0;
    exp_q.delete();
    exp_valid = 1'b0;
    exp_full = 1'b0;
  endtask

  // Does a broadcast this edge deliver the value for tag t?  Returns value through v.
  function automatic bit hit(input bit [TW-1:0] t, output bit [31:0] v);
    v = 32'd0;
    if (cdb_valid && cdb_tag == t) begin v = cdb_value; return 1'b1; end
`ifdef ALU_RS_DUAL_CDB_EN
    if (cdb2_valid && cdb2_tag == t) begin v = cdb2_value; return 1'b1; end
`endif
    return 1'b0;
  endfunction

  // One clock edge of the reservation station, from the pre-edge contents and inputs.
  task automatic model_edge();
    int iss, fr;
    bit [31:0] v;
    slot_t s;
    iss_t r;
    if (rst_in) begin model_reset(); return; end
    if (flush) begin
      foreach (slots[i]) slots[i].busy = 1'b0;
      exp_valid = 1'b0;
    end else if (!rdy_in) begin
      exp_valid = 1'b0;
    end else begin
      iss = -1; fr = -1;
      for (int i = 0; i < N; i++) begin
        if (iss < 0 && slots[i].busy && !slots[i].a_wait && !slots[i].b_wait) iss = i;
        if (fr < 0 && !slots[i].busy) fr = i;
      end
      for (int i = 0; i < N; i++) begin
        if (slots[i].busy && slots[i].a_wait && hit(slots[i].ta, v)) begin slots[i].a = v; slots[i].a_wait = 1'b0; end
        if (slots[i].busy && slots[i].b_wait && hit(slots[i].tb, v)) begin slots[i].b = v; slots[i].b_wait = 1'b0; end
      end
      exp_valid = (iss >= 0);
      if (iss >= 0) begin
        r.op = slots[iss].op; r.a = slots[iss].a; r.b = slots[iss].b;
        r.pc = slots[iss].pc; r.dest = slots[iss].dest;
        exp_q.push_back(r);
        slots[iss].busy = 1'b0;
      end
      if (disp_valid && fr >= 0) begin
        s.busy = 1'b1; s.op = disp_op; s.pc = disp_pc; s.dest = disp_dest;
        s.ta = disp_qj; s.tb = disp_qk; s.a = disp_vj; s.b = disp_vk;
        s.a_wait = disp_qj_busy; s.b_wait = disp_qk_busy;
        if (s.a_wait && hit(s.ta, v)) begin s.a = v; s.a_wait = 1'b0; end
        if (s.b_wait && hit(s.tb, v)) begin s.b = v; s.b_wait = 1'b0; end
        slots[fr] = s;
      end
    end
    exp_full = 1'b1;
    foreach (slots[i]) if (!slots[i].busy) exp_full = 1'b0;
  endtask

  // Monitor: every falling edge compares strobe and full flag, and pops the scoreboard on an issue.
  always @(negedge clk_in) begin
    iss_t e;
    check("alu_valid", alu_valid, exp_valid);
    check("rs_full", rs_full, exp_full);
    if (alu_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_issue", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("issue_record", {alu_op, alu_op1, alu_op2, alu_addr, alu_dest},
              {e.op, e.a, e.b, e.pc, e.dest});
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    disp_valid = 1'b0; cdb_valid = 1'b0; flush = 1'b0; rdy_in = 1'b1;
`ifdef ALU_RS_DUAL_CDB_EN
    cdb2_valid = 1'b0;
`endif
  endtask

  task automatic dispatch(input bit [4:0] op, input bit [31:0] vj, input bit jb, input bit [TW-1:0] qj,
                          input bit [31:0] vk, input bit kb, input bit [TW-1:0] qk,
                          input bit [TW-1:0] dest);
    disp_valid = 1'b1; disp_op = op; disp_vj = vj; disp_qj_busy = jb; disp_qj = qj;
    disp_vk = vk; disp_qk_busy = kb; disp_qk = qk; disp_dest = dest;
    disp_pc = 32'h1000 + {28'd0, dest};
  endtask

  task automatic bcast(input bit [TW-1:0] t, input bit [31:0] v);
    cdb_valid = 1'b1; cdb_tag = t; cdb_value = v;
  endtask

  initial begin
    model_reset();
    step(); step();
    check("reset_outputs", {alu_valid, alu_op, alu_op1, alu_op2, alu_addr, alu_dest, rs_full}, '0);
    rst_in = 1'b0;
    step();

    // ADD, both operands ready
    dispatch(5'd0, 32'd5, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0, 4'd3);
    step(); idle_inputs(); step();
    check("add_issue", {alu_valid, alu_op1, alu_op2, alu_dest}, {1'b1, 32'd5, 32'd7, 4'd3});
    step();
    check("add_once", alu_valid, 1'b0);

    // SUB waiting on tag 2, later woken by the CDB
    dispatch(5'd1, 32'd0, 1'b1, 4'd2, 32'd1, 1'b0, 4'd0, 4'd4);
    step(); idle_inputs(); step();
    check("sub_waits", alu_valid, 1'b0);
    bcast(4'd2, 32'h10); step(); idle_inputs(); step();
    check("sub_wakeup", {alu_valid, alu_op1, alu_dest}, {1'b1, 32'h10, 4'd4});

    // Dispatch-cycle bypass
    dispatch(5'd2, 32'd0, 1'b1, 4'd4, 32'd2, 1'b0, 4'd0, 4'd5);
    bcast(4'd4, 32'd9); step(); idle_inputs(); step();
    check("bypass", {alu_valid, alu_op1}, {1'b1, 32'd9});
    step();

    // Fill all entries on tag 1, overflow dispatch, then drain in index order
    for (int i = 0; i < N; i++) begin
      dispatch(5'd3, 32'd0, 1'b1, 4'd1, 32'(i), 1'b0, 4'd0, TW'(i)); step();
    end
    check("full", rs_full, 1'b1);
    dispatch(5'd3, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd15); step();
    check("full_hold", rs_full, 1'b1);
    idle_inputs(); bcast(4'd1, 32'h55); step(); idle_inputs();
    for (int i = 0; i < N; i++) begin
      step();
      check("drain_order", {alu_valid, alu_dest, alu_op1}, {1'b1, TW'(i), 32'h55});
      if (i == 0) check("full_drop", rs_full, 1'b0);
    end
    step();

    // rdy_in low with two ready entries
    dispatch(5'd4, 32'd0, 1'b1, 4'd6, 32'd1, 1'b0, 4'd0, 4'd8); step();
    dispatch(5'd4, 32'd0, 1'b1, 4'd6, 32'd2, 1'b0, 4'd0, 4'd9); step();
    idle_inputs(); bcast(4'd6, 32'd77); step(); idle_inputs();
    rdy_in = 1'b0;
    bcast(4'd6, 32'd99);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall", alu_valid, 1'b0);
    end
    idle_inputs(); step();
    check("release0", {alu_valid, alu_dest, alu_op1}, {1'b1, 4'd8, 32'd77});
    step();
    check("release1", {alu_valid, alu_dest, alu_op1}, {1'b1, 4'd9, 32'd77});
    step();

    // Flush together with a dispatch
    for (int i = 0; i < 4; i++) begin
      dispatch(5'd5, 32'd0, 1'b1, 4'd7, 32'd0, 1'b0, 4'd0, TW'(i)); step();
    end
    dispatch(5'd5, 32'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 4'd12);
    flush = 1'b1; step(); idle_inputs();
    check("flush_empty", rs_full, 1'b0);
    bcast(4'd7, 32'd1); step(); idle_inputs();
    for (int i = 0; i < 3; i++) begin
      step();
      check("after_flush", alu_valid, 1'b0);
    end

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      disp_valid   = ($urandom_range(0, 9) < 6);
      disp_op      = 5'($urandom_range(0, 31));
      disp_vj      = $urandom;
      disp_vk      = $urandom;
      disp_pc      = $urandom;
      disp_qj      = TW'($urandom_range(0, 3));
      disp_qk      = TW'($urandom_range(0, 3));
      disp_qj_busy = ($urandom_range(0, 1) == 1);
      disp_qk_busy = ($urandom_range(0, 2) == 0);
      disp_dest    = TW'($urandom_range(0, 15));
      cdb_valid    = ($urandom_range(0, 9) < 4);
      cdb_tag      = TW'($urandom_range(0, 3));
      cdb_value    = $urandom;
`ifdef ALU_RS_DUAL_CDB_EN
      cdb2_valid   = ($urandom_range(0, 9) < 3);
      cdb2_tag     = TW'($urandom_range(0, 3));
      cdb2_value   = $urandom;
`endif
      rdy_in       = ($urandom_range(0, 9) != 0);
      flush        = ($urandom_range(0, 49) == 0);
      step();
    end
    idle_inputs();
    for (int i = 0; i < 3; i++) step();

    // Asynchronous reset in the middle of activity
    dispatch(5'd6, 32'd3, 1'b0, 4'd0, 32'd4, 1'b0, 4'd0, 4'd2); step();
    dispatch(5'd6, 32'd3, 1'b1, 4'd3, 32'd4, 1'b0, 4'd0, 4'd3); step();
    idle_inputs();
    rst_in = 1'b1; model_reset(); #1;
    check("async_reset", {alu_valid, alu_dest, alu_op1, rs_full}, '0);
    step(); rst_in = 1'b0;
    step(); step();

    @(negedge clk_in); #1;
    check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station directly upstream of the integer ALU.
- Holds dispatched ALU/branch micro-ops until both source operands are resolved.
- Snoops the common data bus (CDB) to wake operands.
- Issues at most one ready entry per cycle to the ALU with registered outputs: op1, op2, addr, alu_op and the ROB destination tag.
- Sits between the dispatch unit and the ALU; the ALU result returns to the ROB/CDB tagged with alu_dest.

Parameters:
- RS_SIZE, 8, number of entries (power of two, 2..16).
- TAG_W, 4, ROB tag width.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-high
- rdy_in  input  1  global ready; low pauses the block
- flush  input  1  mispredict flush
- disp_valid  input  1  dispatch request
- disp_op  input  5  ALU opcode (codebase alu_op encoding)
- disp_vj  input  32  operand 1 value
- disp_qj  input  TAG_W  operand 1 producer tag
- disp_qj_busy  input  1  1 = operand 1 waits on disp_qj
- disp_vk  input  32  operand 2 value or immediate
- disp_qk  input  TAG_W  operand 2 producer tag
- disp_qk_busy  input  1  1 = operand 2 waits on disp_qk
- disp_pc  input  32  instruction address (for AUIPC)
- disp_dest  input  TAG_W  ROB tag of result
- rs_full  output  1  no free entry
- cdb_valid  input  1  CDB broadcast valid
- cdb_tag  input  TAG_W  broadcast tag
- cdb_value  input  32  broadcast value
- alu_valid  output  1  issue strobe to ALU
- alu_op  output  5  opcode
- alu_op1  output  32  operand 1
- alu_op2  output  32  operand 2
- alu_addr  output  32  pc
- alu_dest  output  TAG_W  ROB tag

Behaviour:
- Reset (asynchronous, rst_in high): all busy bits 0; alu_valid 0; alu_op/op1/op2/addr/dest 0; rs_full 0.
- Entry state: busy, op, vj, qj, qj_busy, vk, qk, qk_busy, pc, dest.
- rs_full is combinational: AND of all busy bits.
- Dispatch:
  - Accepted on a clock edge when rdy_in=1, flush=0, disp_valid=1 and rs_full=0.
  - Writes the lowest-index non-busy entry.
  - disp_valid while rs_full=1 is ignored; the dispatcher must hold it.
- Wakeup: on every edge with rdy_in=1, each busy entry with qj_busy=1 and qj==cdb_tag under cdb_valid=1 loads vj=cdb_value and clears qj_busy. Same rule for k.
- Same-cycle bypass: a dispatched operand whose tag matches a valid CDB in the dispatch cycle is written already resolved with cdb_value.
- Issue select: among entries busy at the start of the cycle with qj_busy=0 and qk_busy=0, the lowest index wins.
- Issue (at the edge):
  - Output registers load that entry.
  - alu_valid is set to 1 and the entry's busy bit is cleared.
  - If no entry is ready, alu_valid is set to 0.
- Latency:
  - Dispatch at edge N with both operands resolved: alu_valid high after edge N+1.
  - CDB wakeup at edge N: issue at edge N+1.
  - Minimum dispatch-to-ALU latency is 2 edges.
- Same-edge dispatch and issue: allowed. A freed index may be reallocated at the next edge, not the same one; selection uses start-of-cycle busy bits.
- rdy_in=0: all entry state and the output data registers hold; alu_valid is cleared to 0 at the edge so an op never issues twice; dispatch and CDB are ignored.
- flush=1 (any rdy_in): at the edge, all busy bits are cleared and alu_valid is cleared. Flush overrides dispatch, wakeup and issue.
- Reset asserted mid-operation aborts everything immediately.
- Tags compare on full TAG_W width; no arithmetic on values.

Optional Feature:
- Macro: ALU_RS_DUAL_CDB_EN.
- Defined:
  - Adds ports cdb2_valid (1), cdb2_tag (TAG_W), cdb2_value (32) for the load-buffer broadcast.
  - Wakeup and dispatch bypass check both buses; if both match the same operand, cdb wins.
- Undefined: the ports are absent and only cdb is snooped.

Test Plan:
- Reset, then dispatch ADD with vj=5, vk=7, both ready, dest=3 → after 2 edges: alu_valid=1, alu_op1=5, alu_op2=7, alu_dest=3; next cycle alu_valid=0.
- Dispatch SUB with qj=2 busy, vk=1; then cdb_valid with tag=2, value=0x10 → issue on the following edge with alu_op1=0x10.
- Dispatch with qj=4 busy in the same cycle as cdb tag=4, value=9 → entry stored resolved; issues next edge with op1=9.
- Fill 8 entries all waiting on tag 1 → rs_full=1 and a 9th dispatch is ignored. Broadcast tag 1 → entries issue in index order 0..7 on consecutive cycles; rs_full drops after the first issue.
- Two entries ready, then rdy_in low for 3 cycles → alu_valid=0 and state held; on release, entry 0 issues then entry 1.
- 4 busy entries, then flush=1 together with disp_valid=1 → all entries empty, nothing issues afterwards, alu_valid=0.
